// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [31:0] DEF_STARTING_ADDR   = 32'h0100_0000;
  localparam logic [31:0] DEF_MEM_DEPTH_BYTES = 32'h0010_0000;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane extract/extend for loads and lane merge for stores
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [4:0]  byte_sh;

  always_comb begin
    byte_sh     = {addr_lo_i, 3'b000};
    lane_byte   = rword_i[byte_sh +: 8];
    lane_half   = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    load_data_o = rword_i;
    merged_o    = wdata_i;
    unique case (size_i)
      SIZE_BYTE: begin
        load_data_o = {{24{~uns_i & lane_byte[7]}}, lane_byte};
        merged_o    = rword_i;
        merged_o[byte_sh +: 8] = wdata_i[7:0];
      end
      SIZE_HALF: begin
        load_data_o = {{16{~uns_i & lane_half[15]}}, lane_half};
        merged_o    = addr_lo_i[1] ? {wdata_i[15:0], rword_i[15:0]}
                                   : {rword_i[31:16], wdata_i[15:0]};
      end
      default: begin
        load_data_o = rword_i;
        merged_o    = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with sub-word RMW stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] STARTING_ADDR   = DEF_STARTING_ADDR,
  parameter logic [31:0] MEM_DEPTH_BYTES = DEF_MEM_DEPTH_BYTES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_write
);

  localparam logic [31:0] LAST_ADDR = STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4;

  lsu_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_data_in_q, mem_data_in_d;

  logic        misaligned;
  logic        req_bad;
  logic [31:0] load_data;
  logic [31:0] merged;

  lsu_align u_align (
    .size_i      (size_q),
    .uns_i       (uns_q),
    .addr_lo_i   (addr_lo_q),
    .rword_i     (mem_data_out),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  always_comb begin
    misaligned = 1'b0;
    unique case (req_size)
      SIZE_HALF: misaligned = req_addr[0];
      SIZE_WORD: misaligned = (req_addr[1:0] != 2'b00);
      default:   misaligned = 1'b0;
    endcase
    req_bad = misaligned || (req_size == SIZE_ILLEGAL) ||
              (req_addr < STARTING_ADDR) || (req_addr > LAST_ADDR);
  end

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    size_d        = size_q;
    uns_d         = uns_q;
    addr_lo_d     = addr_lo_q;
    wdata_d       = wdata_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    rsp_valid_d   = 1'b0;
    rsp_error_d   = 1'b0;
    rsp_rdata_d   = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d   = req_write;
          size_d    = req_size;
          uns_d     = req_unsigned;
          addr_lo_d = req_addr[1:0];
          wdata_d   = req_wdata;
          if (req_bad) begin
            // Rejected requests never touch the memory-side registers.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            mem_address_d = {req_addr[31:2], 2'b00};
            if (req_write && (req_size == SIZE_WORD)) begin
              mem_data_in_d = req_wdata;
              state_d       = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        if (write_q) begin
          mem_data_in_d = merged;
          state_d       = WRITE;
        end else begin
          rsp_rdata_d = load_data;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      WRITE: begin
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      addr_lo_q     <= 2'b00;
      wdata_q       <= 32'h0;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      mem_address_q <= STARTING_ADDR;
      mem_data_in_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      addr_lo_q     <= addr_lo_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_error_q   <= rsp_error_d;
      rsp_rdata_q   <= rsp_rdata_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  // Reset gates the strobe directly so a write in flight is dropped at the reset edge.
  assign mem_read_write = ((state_q == WRITE) && !reset) ? MEM_WRITE : MEM_READ;

endmodule
